// File: rtl/vga_fetch.sv
// Framebuffer prefetch: issues fixed-length burst reads over a linear window
// and buffers returned words in a first-word-fall-through FIFO for the pixel path.
module vga_fetch #(
  parameter int                          WIDTH   = 32,
  parameter int                          ADDRESS = 21,
  parameter int                          FBSIZE  = 18,
  parameter logic [ADDRESS-FBSIZE-1:0]   FBOFF   = '0,
  parameter int                          BSIZE   = 3,
  parameter int                          FDEPTH  = 6
) (
  input  logic               mem_clk_i,
  input  logic               reset_ni,
  input  logic               enable_i,
  input  logic               frame_start_i,
  output logic               mem_read_o,
  input  logic               mem_rack_i,
  input  logic               mem_ready_i,
  output logic [ADDRESS-1:0] mem_addr_o,
  input  logic [WIDTH-1:0]   mem_data_i,
  input  logic               px_read_i,
  output logic [WIDTH-1:0]   px_data_o,
  output logic               px_valid_o,
  output logic               underrun_o,
  output logic [FDEPTH:0]    level_o
);

  localparam int DEPTH = 1 << FDEPTH;
  localparam int BURST = 1 << BSIZE;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t              state, state_next;
  logic [FBSIZE-1:0]   offset;
  logic [BSIZE-1:0]    beat;
  logic                restart;
  logic                can_issue, issue, accept, beat_in, burst_end, push, pop;

  logic [WIDTH-1:0]    fifo_mem [DEPTH];
  logic [FDEPTH-1:0]   wr_ptr, rd_ptr;
  logic [FDEPTH:0]     count;

  // Issuing only with room for a whole burst is what keeps the FIFO from overflowing.
  assign can_issue = enable_i && !frame_start_i && (count <= (FDEPTH+1)'(DEPTH - BURST));
  assign pop       = px_read_i && (count != '0);

  always_ff @(posedge mem_clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (can_issue)                      state_next = REQ;
      REQ:     if (mem_rack_i)                     state_next = DATA;
      DATA:    if (mem_ready_i && beat == BSIZE'(BURST - 1)) state_next = IDLE;
      default:                                     state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read_o = (state == REQ);
    issue      = (state == IDLE) && can_issue;
    accept     = (state == REQ)  && mem_rack_i;
    beat_in    = (state == DATA) && mem_ready_i;
    burst_end  = beat_in && (beat == BSIZE'(BURST - 1));
    push       = beat_in && !restart && !frame_start_i;
  end

  // NOTE: sequential state uses non-blocking assignments; the later assignment wins.
  always_ff @(posedge mem_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem_addr_o <= {FBOFF, {FBSIZE{1'b0}}};
      offset     <= '0;
      beat       <= '0;
      restart    <= 1'b0;
    end else begin
      if (issue) mem_addr_o <= {FBOFF, offset};
      if (state == IDLE && frame_start_i) offset <= '0;
      if (accept) offset <= offset + FBSIZE'(BURST);
      if (frame_start_i && state != IDLE) restart <= 1'b1;
      if (beat_in) beat <= beat + 1'b1;
      if (burst_end) begin
        restart <= 1'b0;
        if (restart || frame_start_i) offset <= '0;
      end
    end
  end

  // NOTE: the storage array is not reset; occupancy alone says which entries are valid.
  always_ff @(posedge mem_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= mem_data_i;
  end

  always_ff @(posedge mem_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      underrun_o <= 1'b0;
    end else if (frame_start_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      underrun_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (FDEPTH+1)'(1);
        2'b01:   count <= count - (FDEPTH+1)'(1);
        default: count <= count;
      endcase
      if (px_read_i && count == '0) underrun_o <= 1'b1;
    end
  end

  assign px_data_o  = fifo_mem[rd_ptr];
  assign px_valid_o = (count != '0);
  assign level_o    = count;

endmodule

// File: tb/tb_vga_fetch.sv
// Randomized bench for vga_fetch: a transaction-level model of the fetch window
// and FIFO contents, plus a small-window instance exercising address wrap.
module tb_vga_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, frame_start, rack, ready, px_read;
  logic [31:0] mdata;
  logic        read, px_valid, underrun;
  logic [20:0] addr;
  logic [31:0] px_data;
  logic [6:0]  level;

  logic        s_rack, s_ready, s_pxr, s_read, s_valid, s_under;
  logic [20:0] s_addr;
  logic [31:0] s_pxdata;
  logic [4:0]  s_level;

  always #5 clk = ~clk;

  vga_fetch dut (
    .mem_clk_i(clk), .reset_ni(rst_n), .enable_i(enable), .frame_start_i(frame_start),
    .mem_read_o(read), .mem_rack_i(rack), .mem_ready_i(ready), .mem_addr_o(addr),
    .mem_data_i(mdata), .px_read_i(px_read), .px_data_o(px_data), .px_valid_o(px_valid),
    .underrun_o(underrun), .level_o(level)
  );

  localparam logic [16:0] S_FBOFF = 17'h1ABCD;

  vga_fetch #(.FBSIZE(4), .FBOFF(S_FBOFF), .FDEPTH(4)) dut_small (
    .mem_clk_i(clk), .reset_ni(rst_n), .enable_i(1'b1), .frame_start_i(1'b0),
    .mem_read_o(s_read), .mem_rack_i(s_rack), .mem_ready_i(s_ready), .mem_addr_o(s_addr),
    .mem_data_i(32'h5A5A_0000), .px_read_i(s_pxr), .px_data_o(s_pxdata), .px_valid_o(s_valid),
    .underrun_o(s_under), .level_o(s_level)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected FIFO contents and the burst currently owed by the fetcher.
  logic [31:0] q[$];
  bit          m_req, m_discard, m_under;
  int          m_phase;          // 0 no burst, 1 waiting for accept, 2 receiving beats
  int          m_beats;
  logic [17:0] m_off;
  logic [20:0] m_addr;

  // Memory environment.
  int          rack_wait, beats_left;
  bit          read_prev, first_seen;
  logic [31:0] first_data;
  logic [20:0] req_log[$];

  task automatic model_edge();
    bit was_empty = (q.size() == 0);
    int lvl       = q.size();
    if (frame_start) begin
      q.delete();
      m_under = 1'b0;
    end else begin
      if (px_read && !was_empty) void'(q.pop_front());
      if (px_read && was_empty)  m_under = 1'b1;
      if (ready && m_phase == 2 && !m_discard) q.push_back(mdata);
    end
    case (m_phase)
      0: if (frame_start) m_off = '0;
         else if (enable && lvl <= 56) begin
           m_phase = 1; m_req = 1'b1; m_addr = {3'b000, m_off};
         end
      1: begin
           if (frame_start) m_discard = 1'b1;
           if (rack) begin
             m_req = 1'b0; m_off = m_off + 18'd8; m_phase = 2; m_beats = 0;
           end
         end
      default: begin
           if (frame_start) m_discard = 1'b1;
           if (ready) begin
             m_beats++;
             if (m_beats == 8) begin
               m_phase = 0;
               if (m_discard) m_off = '0;
               m_discard = 1'b0;
             end
           end
         end
    endcase
  endtask

  task automatic compare_outputs();
    check("mem_read", 64'(read), 64'(m_req));
    if (m_req) check("mem_addr", 64'(addr), 64'(m_addr));
    check("fboff_bits", 64'(addr[20:18]), 64'(0));
    check("level", 64'(level), 64'(q.size()));
    check("px_valid", 64'(px_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("px_data", 64'(px_data), 64'(q[0]));
    check("underrun", 64'(underrun), 64'(m_under));
  endtask

  // Called at a falling edge: check, drive inputs for the next rising edge, advance model.
  task automatic step(input int rd_pct, input int fs_per_mil, input int en_pct, input bit fs_force);
    if (read && !read_prev) req_log.push_back(addr);
    read_prev = read;
    compare_outputs();
    frame_start = fs_force || ($urandom_range(999) < fs_per_mil);
    px_read     = ($urandom_range(99) < rd_pct);
    enable      = ($urandom_range(99) < en_pct);
    rack  = 1'b0;
    ready = 1'b0;
    if (beats_left > 0 && $urandom_range(3) != 0) begin
      ready = 1'b1;
      mdata = $urandom;
      beats_left--;
      if (!first_seen) begin first_seen = 1'b1; first_data = mdata; end
    end else if (beats_left == 0 && read) begin
      if (rack_wait == 0) begin
        rack = 1'b1; rack_wait = $urandom_range(3); beats_left = 8;
      end else rack_wait--;
    end
    model_edge();
    @(negedge clk);
  endtask

  bit wrap_done = 1'b0;

  // Small window: 16 words, two bursts, so request offsets must go 0, 8, 0, 8, 0.
  initial begin
    logic [20:0] s_log[$];
    int s_left = 0;
    bit s_prev = 1'b0;
    s_rack = 1'b0; s_ready = 1'b0; s_pxr = 1'b1;
    wait (rst_n === 1'b1);
    @(negedge clk);
    for (int c = 0; c < 400 && s_log.size() < 5; c++) begin
      if (s_read && !s_prev) s_log.push_back(s_addr);
      s_prev  = s_read;
      s_rack  = 1'b0;
      s_ready = 1'b0;
      if (s_left > 0) begin s_ready = 1'b1; s_left--; end
      else if (s_read) begin s_rack = 1'b1; s_left = 8; end
      @(negedge clk);
    end
    check("wrap_req_count", 64'(s_log.size()), 64'(5));
    for (int i = 0; i < s_log.size(); i++) begin
      check("wrap_offset", 64'(s_log[i][3:0]), 64'((i % 2) * 8));
      check("wrap_fboff", 64'(s_log[i][20:4]), 64'(S_FBOFF));
    end
    wrap_done = 1'b1;
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; rack = 1'b0; ready = 1'b0;
    px_read = 1'b0; mdata = '0;
    q.delete(); m_req = 0; m_discard = 0; m_under = 0; m_phase = 0; m_beats = 0;
    m_off = '0; m_addr = '0; rack_wait = 0; beats_left = 0; read_prev = 0; first_seen = 0;
    first_data = '0;
    repeat (2) @(negedge clk);
    check("rst_read", 64'(read), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_valid", 64'(px_valid), 64'(0));
    check("rst_underrun", 64'(underrun), 64'(0));
    rst_n = 1'b1;

    // Fill with no pops: eight bursts at 0..56, then a stall at 64 words.
    for (int i = 0; i < 2000 && level != 7'd64; i++) step(0, 0, 100, 0);
    check("fill_level", 64'(level), 64'(64));
    check("fill_head", 64'(px_data), 64'(first_data));
    repeat (30) step(0, 0, 100, 0);
    check("stall_no_req", 64'(read), 64'(0));
    check("fill_req_count", 64'(req_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < req_log.size(); i++)
      check("fill_req_addr", 64'(req_log[i]), 64'(i * 8));
    repeat (8) step(100, 0, 100, 0);
    repeat (20) step(0, 0, 100, 0);
    check("ninth_req_present", 64'(req_log.size() > 8), 64'(1));
    if (req_log.size() > 8) check("ninth_req_addr", 64'(req_log[8]), 64'(64));

    // Randomized traffic: pop rate, frame restarts and enable gating vary per phase.
    for (int p = 0; p < 12; p++) begin
      int rd = $urandom_range(100);
      int fs = $urandom_range(15);
      int en = (p % 4 == 3) ? 70 : 100;
      repeat (1500) step(rd, fs, en, 0);
    end

    // Drain with fetch disabled, then underrun must be set and cleared by frame start.
    repeat (200) step(100, 0, 0, 0);
    check("drain_level", 64'(level), 64'(0));
    check("underrun_set", 64'(underrun), 64'(1));
    step(0, 0, 0, 1);
    check("underrun_clear", 64'(underrun), 64'(0));
    step(0, 0, 0, 0);

    for (int i = 0; i < 1000 && !wrap_done; i++) @(negedge clk);
    if (!wrap_done) check("wrap_timeout", 64'(0), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
